ad9866_gain_sched: RTL and testbench

- Sits directly upstream of the AD9866 SPI configuration block; generates its rx/tx gain write requests.
- Accepts gain updates from the host command decoder and keeps the latest value per path.
- Issues ext_rx_rqst / ext_tx_rqst one at a time and holds each request until the SPI engine takes it (sen_n falls).
- Guarantees one SPI frame per request, never both requests together, and no requests during the power-up init sequence.

---
 rtl/ad9866_pkg.sv | 32 +++
 rtl/ad9866_gain_track.sv | 71 +++++++
 rtl/ad9866_gain_sched.sv | 168 ++++++++++++++++
 tb/tb_ad9866_gain_sched.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9866_pkg.sv
// Shared types and defaults for the AD9866 gain-write scheduler.
package ad9866_pkg;

  typedef logic [5:0]  gain_t;
  typedef logic [15:0] timer_t;

  // Scheduler states. These are plain constants rather than an enum so the encoding
  // stays fixed for existing users of this package.
  typedef logic [2:0] sched_state_t;
  localparam sched_state_t StHoldoff = 3'd0;
  localparam sched_state_t StIdle    = 3'd1;
  localparam sched_state_t StReqRx   = 3'd2;
  localparam sched_state_t StWaitRx  = 3'd3;
  localparam sched_state_t StReqTx   = 3'd4;
  localparam sched_state_t StWaitTx  = 3'd5;
  localparam sched_state_t StGap     = 3'd6;

  localparam int unsigned INIT_HOLDOFF_DEF = 4096;
  localparam int unsigned ACK_TIMEOUT_DEF  = 255;
  localparam int unsigned GAP_CYCLES_DEF   = 4;

  // Move one code from cur toward tgt, or stay put if they already match.
  function automatic gain_t ramp_step(input gain_t cur, input gain_t tgt);
    if (tgt > cur) begin
      return cur + 6'd1;
    end else if (tgt < cur) begin
      return cur - 6'd1;
    end
    return cur;
  endfunction

endpackage

// File: rtl/ad9866_gain_track.sv
// Per-path gain bookkeeping: latest target, last value written to the chip (shadow),
// the code currently presented to the SPI block, and the pending-write flag.
module ad9866_gain_track
  import ad9866_pkg::*;
#(
  parameter bit RampEn = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gain_valid_i,
  input  logic [5:0] gain_in_i,
  input  logic       issue_i,
  input  logic       ack_i,
  input  logic       timeout_i,
  output logic [5:0] gain_o,
  output logic       pend_o
);

  gain_t target_q, target_d;
  gain_t shadow_q, shadow_d;
  gain_t gain_q, gain_d;
  gain_t step;
  logic  pend_q, pend_d;

  // With ramping, each write moves one code from what the chip holds now.
  assign step = RampEn ? ramp_step(shadow_q, target_q) : target_q;

  // Target capture, write issue and completion bookkeeping.
  always_comb begin
    target_d = target_q;
    shadow_d = shadow_q;
    gain_d   = gain_q;
    pend_d   = pend_q;
    if (gain_valid_i) begin
      target_d = gain_in_i;
      pend_d   = (gain_in_i != shadow_q);
    end
    if (issue_i) begin
      gain_d = step;
      pend_d = (step != target_q);
    end
    // A completed write re-judges pending against the fresh shadow, so an update that
    // arrived mid-frame yields exactly one follow-up write (or none if it matches).
    if (ack_i) begin
      shadow_d = gain_q;
      pend_d   = (target_d != gain_q);
    end
    if (timeout_i) begin
      pend_d = 1'b1;
    end
  end

  // Path state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      target_q <= '0;
      shadow_q <= '0;
      gain_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      target_q <= target_d;
      shadow_q <= shadow_d;
      gain_q   <= gain_d;
      pend_q   <= pend_d;
    end
  end

  assign gain_o = gain_q;
  assign pend_o = pend_q;

endmodule

// File: rtl/ad9866_gain_sched.sv
// AD9866 RX/TX gain-write scheduler feeding the SPI configuration block.
// Holds off during power-up init, issues one request at a time, and releases each
// request one cycle after the SPI engine starts its frame.
// Define AD9866_TX_GAIN_RAMP_EN to step TX gain by one code per write.
module ad9866_gain_sched
  import ad9866_pkg::*;
#(
  parameter int unsigned INIT_HOLDOFF = INIT_HOLDOFF_DEF,
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
  parameter int unsigned GAP_CYCLES   = GAP_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       gain_valid,
  input  logic [5:0] rx_gain_in,
  input  logic [5:0] tx_gain_in,
  input  logic       ptt,
  input  logic       sen_n,
  output logic       ext_rx_rqst,
  output logic [5:0] rx_gain,
  output logic       ext_tx_rqst,
  output logic [5:0] tx_gain,
  output logic       busy,
  output logic       timeout_err
);

`ifdef AD9866_TX_GAIN_RAMP_EN
  localparam bit TxRampEn = 1'b1;
`else
  localparam bit TxRampEn = 1'b0;
`endif

  localparam timer_t HoldoffLast = timer_t'(INIT_HOLDOFF - 1);
  localparam timer_t AckLast     = timer_t'(ACK_TIMEOUT - 1);
  localparam timer_t GapLast     = timer_t'(GAP_CYCLES - 1);

  sched_state_t state_q, state_d;
  timer_t       timer_q, timer_d;
  logic         err_q, err_d;
  logic         rx_issue, tx_issue, rx_ack, tx_ack, rx_to, tx_to;
  logic         rx_pend, tx_pend;

  // Arbitration, request handshake, timeout and gap sequencing.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    err_d    = err_q;
    rx_issue = 1'b0;
    tx_issue = 1'b0;
    rx_ack   = 1'b0;
    tx_ack   = 1'b0;
    rx_to    = 1'b0;
    tx_to    = 1'b0;
    case (state_q)
      StHoldoff: begin
        if (timer_q == HoldoffLast) begin
          state_d = StIdle;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StIdle: begin
        timer_d = '0;
        if (sen_n) begin
          if (tx_pend && (ptt || !rx_pend)) begin
            tx_issue = 1'b1;
            state_d  = StReqTx;
          end else if (rx_pend) begin
            rx_issue = 1'b1;
            state_d  = StReqRx;
          end
        end
      end
      StReqRx: begin
        if (!sen_n) begin
          rx_ack  = 1'b1;
          state_d = StWaitRx;
        end else if (timer_q == AckLast) begin
          rx_to   = 1'b1;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StReqTx: begin
        if (!sen_n) begin
          tx_ack  = 1'b1;
          state_d = StWaitTx;
        end else if (timer_q == AckLast) begin
          tx_to   = 1'b1;
          err_d   = 1'b1;
          timer_d = '0;
          state_d = StGap;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      StWaitRx, StWaitTx: begin
        if (sen_n) begin
          timer_d = '0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          state_d = StIdle;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: begin
        state_d = StHoldoff;
        timer_d = '0;
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StHoldoff;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  ad9866_gain_track #(
    .RampEn (1'b0)
  ) u_rx_track (
    .clk          (clk),
    .reset        (reset),
    .gain_valid_i (gain_valid),
    .gain_in_i    (rx_gain_in),
    .issue_i      (rx_issue),
    .ack_i        (rx_ack),
    .timeout_i    (rx_to),
    .gain_o       (rx_gain),
    .pend_o       (rx_pend)
  );

  ad9866_gain_track #(
    .RampEn (TxRampEn)
  ) u_tx_track (
    .clk          (clk),
    .reset        (reset),
    .gain_valid_i (gain_valid),
    .gain_in_i    (tx_gain_in),
    .issue_i      (tx_issue),
    .ack_i        (tx_ack),
    .timeout_i    (tx_to),
    .gain_o       (tx_gain),
    .pend_o       (tx_pend)
  );

  // Requests decode straight from registered state so they drop the moment reset hits.
  assign ext_rx_rqst = (state_q == StReqRx);
  assign ext_tx_rqst = (state_q == StReqTx);
  assign busy        = (state_q != StIdle);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_ad9866_gain_sched.sv
// Self-checking bench for ad9866_gain_sched with a behavioural SPI responder and a
// write-sequence reference model.
module tb_ad9866_gain_sched;

  localparam int INIT_HOLDOFF = 4096;
  localparam int ACK_TIMEOUT  = 255;
  localparam int GAP_CYCLES   = 4;
  localparam int FRAME        = 34;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gain_valid = 1'b0;
  logic [5:0] rx_gain_in = '0;
  logic [5:0] tx_gain_in = '0;
  logic       ptt = 1'b0;
  logic       sen_n = 1'b1;
  logic       ext_rx_rqst, ext_tx_rqst, busy, timeout_err;
  logic [5:0] rx_gain, tx_gain;

  int n_cmp = 0;
  int n_err = 0;

  bit         spi_en = 1'b1;
  logic [6:0] frames[$];   // {is_tx, code} seen by the SPI responder
  logic [6:0] exp_q[$];    // {is_tx, code} predicted by the model
  logic [5:0] cur_rx = '0, cur_tx = '0;
  logic [5:0] sh_rx = '0, sh_tx = '0;

  int cyc = 0;
  int first_rq = -1;
  int last_rise = -1;
  int min_gap = 1000;
  int both_viol = 0;
  int hold_viol = 0;
  logic sen_prev = 1'b1;
  logic rq_prev = 1'b0;

  ad9866_gain_sched dut (
    .clk         (clk),
    .reset       (reset),
    .gain_valid  (gain_valid),
    .rx_gain_in  (rx_gain_in),
    .tx_gain_in  (tx_gain_in),
    .ptt         (ptt),
    .sen_n       (sen_n),
    .ext_rx_rqst (ext_rx_rqst),
    .rx_gain     (rx_gain),
    .ext_tx_rqst (ext_tx_rqst),
    .tx_gain     (tx_gain),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  // SPI responder: one frame per observed request, starting two cycles later.
  always begin
    @(negedge clk);
    if (spi_en && !reset && (ext_rx_rqst || ext_tx_rqst)) begin
      frames.push_back(ext_tx_rqst ? {1'b1, tx_gain} : {1'b0, rx_gain});
      repeat (2) @(negedge clk);
      sen_n = 1'b0;
      repeat (FRAME) @(negedge clk);
      sen_n = 1'b1;
    end
  end

  // Protocol monitor, sampled just after each rising edge.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      cyc = 0;
      first_rq = -1;
      last_rise = -1;
      rq_prev = 1'b0;
      sen_prev = 1'b1;
    end else begin
      cyc++;
      if (ext_rx_rqst && ext_tx_rqst) both_viol++;
      if ((ext_rx_rqst || ext_tx_rqst) && !sen_n) hold_viol++;
      if (sen_n && !sen_prev) last_rise = cyc;
      if ((ext_rx_rqst || ext_tx_rqst) && !rq_prev) begin
        if (first_rq < 0) first_rq = cyc;
        if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap = cyc - last_rise;
      end
      sen_prev = sen_n;
      rq_prev = ext_rx_rqst || ext_tx_rqst;
    end
  end

  // Reference model: predicts the SPI writes an update causes from a quiet state.
  task automatic model_update(input logic [5:0] rx, input logic [5:0] tx, input logic p);
    logic [6:0] txs[$];
    logic [5:0] g;
    g = sh_tx;
`ifdef AD9866_TX_GAIN_RAMP_EN
    while (g != tx) begin
      g = (tx > g) ? g + 6'd1 : g - 6'd1;
      txs.push_back({1'b1, g});
    end
`else
    if (tx != g) txs.push_back({1'b1, tx});
`endif
    if (rx != sh_rx && !p) exp_q.push_back({1'b0, rx});
    foreach (txs[i]) exp_q.push_back(txs[i]);
    if (rx != sh_rx && p) exp_q.push_back({1'b0, rx});
    sh_rx = rx;
    sh_tx = tx;
  endtask

  task automatic send(input logic [5:0] rx, input logic [5:0] tx, input logic p);
    @(negedge clk);
    rx_gain_in = rx;
    tx_gain_in = tx;
    ptt = p;
    gain_valid = 1'b1;
    @(negedge clk);
    gain_valid = 1'b0;
    cur_rx = rx;
    cur_tx = tx;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int quiet = 0;
    int n = 0;
    repeat (3) @(negedge clk);
    while (quiet < 4 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && !ext_rx_rqst && !ext_tx_rqst && sen_n) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 4) begin
      n_err++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic clear_q();
    frames.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({ext_rx_rqst, ext_tx_rqst, busy, timeout_err} !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_ctl: rx_rq,tx_rq,busy,err=%b, required 0010",
               {ext_rx_rqst, ext_tx_rqst, busy, timeout_err});
    end
    n_cmp++;
    if ({rx_gain, tx_gain} !== 12'h000) begin
      n_err++;
      $display("FAIL reset_gain: rx_gain=%h tx_gain=%h, required 00 00", rx_gain, tx_gain);
    end
  endtask

  task automatic test_holdoff();
    clear_q();
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    model_update(6'h20, 6'h00, 1'b0);
    send(6'h20, 6'h00, 1'b0);
    repeat (2000) @(negedge clk);
    n_cmp++;
    if ({busy, ext_rx_rqst, ext_tx_rqst} !== 3'b100) begin
      n_err++;
      $display("FAIL holdoff_busy: busy,rx_rq,tx_rq=%b, required 100",
               {busy, ext_rx_rqst, ext_tx_rqst});
    end
    wait_idle(6000, "holdoff");
    n_cmp++;
    if (first_rq < INIT_HOLDOFF) begin
      n_err++;
      $display("FAIL holdoff_first: first request at cycle %0d, required >= %0d",
               first_rq, INIT_HOLDOFF);
    end
    n_cmp++;
    if (frames.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL holdoff_count: %0d frames, required %0d", frames.size(), exp_q.size());
    end else begin
      for (int i = 0; i < frames.size(); i++) begin
        n_cmp++;
        if (frames[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL holdoff_frame%0d: got %h, required %h", i, frames[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_priority();
    clear_q();
    model_update(6'h11, 6'h2A, 1'b1);
    send(6'h11, 6'h2A, 1'b1);
    wait_idle(6000, "prio");
    n_cmp++;
    if (frames.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL prio_count: %0d frames, required %0d", frames.size(), exp_q.size());
    end else begin
      for (int i = 0; i < frames.size(); i++) begin
        n_cmp++;
        if (frames[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL prio_frame%0d: got %h, required %h", i, frames[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_midwrite();
    int n = 0;
    clear_q();
    model_update(6'h07, cur_tx, 1'b0);
    send(6'h07, cur_tx, 1'b0);
    while (sen_n && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (sen_n !== 1'b0) begin
      n_err++;
      $display("FAIL mid_frame_start: sen_n=%b, required 0 within 50 cycles", sen_n);
    end
    repeat (5) @(negedge clk);
    model_update(6'h05, cur_tx, 1'b0);
    send(6'h05, cur_tx, 1'b0);
    wait_idle(2000, "mid");
    n_cmp++;
    if (frames.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL mid_count: %0d frames, required %0d", frames.size(), exp_q.size());
    end else begin
      for (int i = 0; i < frames.size(); i++) begin
        n_cmp++;
        if (frames[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL mid_frame%0d: got %h, required %h", i, frames[i], exp_q[i]);
        end
      end
    end
    clear_q();
    model_update(6'h05, cur_tx, 1'b0);
    send(6'h05, cur_tx, 1'b0);
    wait_idle(2000, "same");
    n_cmp++;
    if (frames.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL same_value: %0d frames, required %0d", frames.size(), exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    int hc = 0;
    clear_q();
    spi_en = 1'b0;
    model_update(6'h33, cur_tx, 1'b0);
    send(6'h33, cur_tx, 1'b0);
    while (!ext_rx_rqst && n < 20) begin
      @(negedge clk);
      n++;
    end
    while (ext_rx_rqst && hc < 400) begin
      hc++;
      @(negedge clk);
    end
    n_cmp++;
    if (hc !== ACK_TIMEOUT) begin
      n_err++;
      $display("FAIL to_len: request high %0d cycles, required %0d", hc, ACK_TIMEOUT);
    end
    n_cmp++;
    if (timeout_err !== 1'b1) begin
      n_err++;
      $display("FAIL to_err: timeout_err=%b, required 1", timeout_err);
    end
    n = 0;
    while (!ext_rx_rqst && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if ({ext_rx_rqst, rx_gain} !== {1'b1, 6'h33}) begin
      n_err++;
      $display("FAIL to_retry: rx_rq=%b rx_gain=%h, required 1 33", ext_rx_rqst, rx_gain);
    end
    spi_en = 1'b1;
    wait_idle(2000, "to");
    n_cmp++;
    if (frames.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL to_count: %0d frames, required %0d", frames.size(), exp_q.size());
    end else begin
      for (int i = 0; i < frames.size(); i++) begin
        n_cmp++;
        if (frames[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL to_frame%0d: got %h, required %h", i, frames[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] rx, tx;
    logic p;
    for (int it = 0; it < 8; it++) begin
      clear_q();
      rx = ($urandom_range(0, 1) == 0) ? cur_rx : 6'($urandom_range(0, 63));
      tx = ($urandom_range(0, 1) == 0) ? cur_tx : 6'($urandom_range(0, 63));
      p = 1'($urandom_range(0, 1));
      model_update(rx, tx, p);
      send(rx, tx, p);
      wait_idle(4000, "rand");
      n_cmp++;
      if (frames.size() !== exp_q.size()) begin
        n_err++;
        $display("FAIL rand%0d_count: %0d frames, required %0d", it, frames.size(),
                 exp_q.size());
      end else begin
        for (int i = 0; i < frames.size(); i++) begin
          n_cmp++;
          if (frames[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL rand%0d_frame%0d: got %h, required %h", it, i, frames[i],
                     exp_q[i]);
          end
        end
      end
    end
  endtask

  task automatic test_tx_step();
    model_update(cur_rx, 6'h00, 1'b0);
    send(cur_rx, 6'h00, 1'b0);
    wait_idle(4000, "tx_zero");
    clear_q();
`ifdef AD9866_TX_GAIN_RAMP_EN
    begin
      int n = 0;
      send(cur_rx, 6'h03, 1'b0);
      while (frames.size() < 2 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (sen_n && n < 50) begin
        @(negedge clk);
        n++;
      end
      n = 0;
      while (!sen_n && n < 100) begin
        @(negedge clk);
        n++;
      end
      send(cur_rx, 6'h01, 1'b0);
      exp_q.push_back({1'b1, 6'h01});
      exp_q.push_back({1'b1, 6'h02});
      exp_q.push_back({1'b1, 6'h01});
      sh_tx = 6'h01;
    end
`else
    model_update(cur_rx, 6'h03, 1'b0);
    send(cur_rx, 6'h03, 1'b0);
`endif
    wait_idle(2000, "tx_step");
    n_cmp++;
    if (frames.size() !== exp_q.size()) begin
      n_err++;
      $display("FAIL tx_step_count: %0d frames, required %0d", frames.size(), exp_q.size());
    end else begin
      for (int i = 0; i < frames.size(); i++) begin
        n_cmp++;
        if (frames[i] !== exp_q[i]) begin
          n_err++;
          $display("FAIL tx_step_frame%0d: got %h, required %h", i, frames[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_protocol();
    n_cmp++;
    if (both_viol !== 0) begin
      n_err++;
      $display("FAIL both_rqst: %0d cycles with both requests, required 0", both_viol);
    end
    n_cmp++;
    if (hold_viol !== 0) begin
      n_err++;
      $display("FAIL rqst_hold: %0d late-drop cycles, required 0", hold_viol);
    end
    n_cmp++;
    if (min_gap < GAP_CYCLES) begin
      n_err++;
      $display("FAIL gap: min sen_n-high to request %0d cycles, required >= %0d", min_gap,
               GAP_CYCLES);
    end
  endtask

  task automatic test_reset_midreq();
    int n = 0;
    clear_q();
    spi_en = 1'b0;
    send(cur_rx, cur_tx ^ 6'h15, 1'b1);
    while (!ext_tx_rqst && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (ext_tx_rqst !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: ext_tx_rqst=%b, required 1", ext_tx_rqst);
    end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ext_tx_rqst, busy, tx_gain} !== {1'b0, 1'b1, 6'h00}) begin
      n_err++;
      $display("FAIL rst_async: tx_rq=%b busy=%b tx_gain=%h, required 0 1 00", ext_tx_rqst,
               busy, tx_gain);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    spi_en = 1'b1;
    cur_rx = '0; cur_tx = '0; sh_rx = '0; sh_tx = '0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if ({busy, ext_rx_rqst, ext_tx_rqst, timeout_err} !== 4'b1000) begin
      n_err++;
      $display("FAIL rst_holdoff: busy,rx_rq,tx_rq,err=%b, required 1000",
               {busy, ext_rx_rqst, ext_tx_rqst, timeout_err});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_holdoff();
    test_priority();
    test_midwrite();
    test_timeout();
    test_random();
    test_tx_step();
    test_protocol();
    test_reset_midreq();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
